// File: rtl/apb4_cmd_master.sv
// Single-outstanding APB4 master: turns a valid/ready command stream into APB4
// transfers and returns each result on a valid/ready response stream.
module apb4_cmd_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DS      = DW / 8,
  parameter int TIMEOUT = 256
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [AW-1:0] CMD_ADDR,
  input  logic          CMD_WRITE,
  input  logic [DW-1:0] CMD_WDATA,
  input  logic [DS-1:0] CMD_STRB,
  input  logic [2:0]    CMD_PROT,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [DW-1:0] RSP_RDATA,
  output logic          RSP_ERR,
  output logic          RSP_TIMEOUT,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  output logic [DS-1:0] PSTRB,
  output logic [2:0]    PPROT,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t          state_q, state_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [DS-1:0]   pstrb_q, pstrb_d;
  logic [2:0]      pprot_q, pprot_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_hit;

  // Abort fires on the ACCESS cycle where the counter already sits at its limit.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_MAX);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= S_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (CMD_VALID) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (PREADY || timeout_hit) state_d = S_RESP;
      S_RESP:   if (RSP_READY) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = CMD_ADDR;
          pwrite_d  = CMD_WRITE;
          pwdata_d  = CMD_WDATA;
          pstrb_d   = CMD_WRITE ? CMD_STRB : '0;
          pprot_d   = CMD_PROT;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      S_ACCESS: begin
        // A completing slave takes priority over a simultaneous time-out.
        if (PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (RSP_READY) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign CMD_READY   = (state_q == S_IDLE);
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = pprot_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_ERR     = rsp_err_q;
  assign RSP_TIMEOUT = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Self-checking bench for apb4_cmd_master: table vectors, hand-written corner
// sequences and random commands against a transaction-level reference model.
module tb_apb4_cmd_master;

  localparam int TO = 8;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [31:0] CMD_ADDR, CMD_WDATA;
  logic [3:0]  CMD_STRB;
  logic [2:0]  CMD_PROT;
  logic        RSP_VALID, RSP_READY, RSP_ERR, RSP_TIMEOUT;
  logic [31:0] RSP_RDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;

  int checks = 0;
  int errors = 0;

  apb4_cmd_master #(.AW(32), .DW(32), .DS(4), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR),
    .CMD_WRITE(CMD_WRITE), .CMD_WDATA(CMD_WDATA), .CMD_STRB(CMD_STRB),
    .CMD_PROT(CMD_PROT),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // APB slave: 16-word memory, configurable wait states and error response
  int unsigned slv_waits = 0;
  logic        slv_err   = 1'b0;
  int unsigned acc_cnt   = 0;
  logic [31:0] smem [16] = '{default: 32'h0};

  assign PREADY  = (acc_cnt >= slv_waits);
  assign PSLVERR = slv_err & PREADY;
  assign PRDATA  = smem[PADDR[5:2]];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE)
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) smem[PADDR[5:2]][8*b +: 8] <= PWDATA[8*b +: 8];
  end

  // Reference model state
  logic [31:0] ref_mem [16] = '{default: 32'h0};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot,
                         input int unsigned waits, input logic perr, input int hold,
                         output logic [31:0] r_rdata, output logic r_err, output logic r_to,
                         output int lat, output int npsel, output int npen,
                         output logic apb_ok, output logic rsp_ok);
    logic [3:0] exp_strb;
    exp_strb = wr ? strb : 4'h0;
    @(negedge PCLK);
    slv_waits = waits; slv_err = perr; RSP_READY = 1'b0;
    CMD_VALID = 1'b1; CMD_ADDR = addr; CMD_WRITE = wr; CMD_WDATA = wdata;
    CMD_STRB = strb; CMD_PROT = prot;
    check("cmd_ready_idle", CMD_READY, 1'b1);
    @(posedge PCLK);
    #1;
    CMD_VALID = 1'b0; CMD_ADDR = $urandom; CMD_WDATA = $urandom; CMD_WRITE = ~wr;
    CMD_STRB = 4'($urandom); CMD_PROT = 3'($urandom);
    lat = 1; npsel = 0; npen = 0; apb_ok = 1'b1; rsp_ok = 1'b1;
    @(negedge PCLK);
    while (!RSP_VALID && lat < 40) begin
      if (PSEL) begin
        npsel++;
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata ||
            PSTRB !== exp_strb || PPROT !== prot) apb_ok = 1'b0;
      end
      if (PENABLE) npen++;
      @(posedge PCLK);
      lat++;
      @(negedge PCLK);
    end
    check("psel_low_in_resp", {PSEL, PENABLE}, 2'b00);
    r_rdata = RSP_RDATA; r_err = RSP_ERR; r_to = RSP_TIMEOUT;
    for (int i = 0; i < hold; i++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      if (!RSP_VALID || CMD_READY || RSP_RDATA !== r_rdata || RSP_ERR !== r_err ||
          RSP_TIMEOUT !== r_to) rsp_ok = 1'b0;
    end
    RSP_READY = 1'b1;
    @(posedge PCLK);
    #1 RSP_READY = 1'b0;
  endtask

  task automatic exec(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int unsigned waits, input logic perr,
                      input int hold, input logic use_tab, input logic [31:0] t_rdata,
                      input logic t_err, input logic t_to, input int t_lat);
    logic [31:0] m_rdata, r_rdata;
    logic        m_err, m_to, r_err, r_to, apb_ok, rsp_ok;
    int          m_lat, lat, npsel, npen;
    logic [2:0]  prot;
    int          idx;
    idx  = int'(addr[5:2]);
    prot = 3'($urandom);
    m_to    = (waits >= TO);
    m_lat   = 2 + (m_to ? TO : int'(waits) + 1);
    m_rdata = m_to ? 32'hFFFF_FFFF : (wr ? 32'h0 : ref_mem[idx]);
    m_err   = m_to ? 1'b1 : perr;
    if (!m_to && wr) ref_mem[idx] = merge(ref_mem[idx], wdata, strb);
    run_cmd(addr, wr, wdata, strb, prot, waits, perr, hold,
            r_rdata, r_err, r_to, lat, npsel, npen, apb_ok, rsp_ok);
    check("rsp_rdata", r_rdata, m_rdata);
    check("rsp_err", r_err, m_err);
    check("rsp_timeout", r_to, m_to);
    check("latency", lat, m_lat);
    check("psel_cycles", npsel, m_lat - 1);
    check("penable_cycles", npen, m_lat - 2);
    check("apb_stable", apb_ok, 1'b1);
    check("rsp_stable", rsp_ok, 1'b1);
    if (use_tab) begin
      check("tab_rdata", r_rdata, t_rdata);
      check("tab_err", {r_err, r_to}, {t_err, t_to});
      check("tab_latency", lat, t_lat);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!RSP_VALID && n < 40) begin
      @(posedge PCLK);
      @(negedge PCLK);
      n++;
    end
    check("drain_rsp_seen", RSP_VALID, 1'b1);
    RSP_READY = 1'b1;
    @(posedge PCLK);
    #1 RSP_READY = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int unsigned waits;
    logic        perr;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_to;
    int          e_lat;
  } vec_t;

  vec_t vt[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd0, addr;
    logic        seen;
    int          w, r;

    vt[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0,    1'b0, 32'h0,        1'b0, 1'b0, 3};
    vt[1]  = '{1'b0, 32'h10, 32'h0,        4'hA, 0,    1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 3};
    vt[2]  = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 0,    1'b0, 32'h0,        1'b0, 1'b0, 3};
    vt[3]  = '{1'b1, 32'h20, 32'h11223344, 4'h5, 0,    1'b0, 32'h0,        1'b0, 1'b0, 3};
    vt[4]  = '{1'b0, 32'h20, 32'h0,        4'hF, 0,    1'b0, 32'hFF22FF44, 1'b0, 1'b0, 3};
    vt[5]  = '{1'b0, 32'h10, 32'h0,        4'h0, 3,    1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 6};
    vt[6]  = '{1'b0, 32'h20, 32'h0,        4'h0, 1000, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 10};
    vt[7]  = '{1'b0, 32'h20, 32'h0,        4'h0, 7,    1'b0, 32'hFF22FF44, 1'b0, 1'b0, 10};
    vt[8]  = '{1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 2,    1'b0, 32'h0,        1'b0, 1'b0, 5};
    vt[9]  = '{1'b1, 32'h30, 32'h12345678, 4'hF, 1000, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 10};
    vt[10] = '{1'b0, 32'h30, 32'h0,        4'hF, 0,    1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 3};

    PRESET = 1'b1; CMD_VALID = 1'b0; CMD_ADDR = '0; CMD_WRITE = 1'b0; CMD_WDATA = '0;
    CMD_STRB = '0; CMD_PROT = '0; RSP_READY = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    check("reset_apb_ctrl", {PSEL, PENABLE, PWRITE}, 3'b000);
    check("reset_apb_data", {PADDR, PWDATA}, 64'h0);
    check("reset_strb_prot", {PSTRB, PPROT}, 7'h0);
    check("reset_rsp", {RSP_VALID, RSP_ERR, RSP_TIMEOUT}, 3'b000);
    check("reset_rdata", RSP_RDATA, 32'h0);
    check("reset_cmd_ready", CMD_READY, 1'b1);

    for (int i = 0; i < 11; i++)
      exec(vt[i].addr, vt[i].wr, vt[i].wdata, vt[i].strb, vt[i].waits, vt[i].perr,
           i % 2, 1'b1, vt[i].e_rdata, vt[i].e_err, vt[i].e_to, vt[i].e_lat);

    // Response back-pressure with a command waiting behind it
    @(negedge PCLK);
    slv_waits = 0; slv_err = 1'b0; RSP_READY = 1'b0;
    CMD_VALID = 1'b1; CMD_ADDR = 32'h10; CMD_WRITE = 1'b0; CMD_STRB = 4'hF; CMD_PROT = 3'h2;
    @(posedge PCLK);
    @(posedge PCLK);
    @(posedge PCLK);
    @(negedge PCLK);
    check("bp_rsp_valid_3_edges", RSP_VALID, 1'b1);
    rd0 = RSP_RDATA;
    check("bp_rdata", rd0, ref_mem[4]);
    seen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (CMD_READY || !RSP_VALID || RSP_RDATA !== rd0 || RSP_ERR || RSP_TIMEOUT) seen = 1'b0;
      @(posedge PCLK);
      @(negedge PCLK);
    end
    check("bp_hold_stable", seen, 1'b1);
    RSP_READY = 1'b1; CMD_ADDR = 32'h20;
    @(posedge PCLK);
    #1 RSP_READY = 1'b0;
    @(negedge PCLK);
    check("bp_after_handshake", {RSP_VALID, CMD_READY}, 2'b01);
    @(posedge PCLK);
    #1 CMD_VALID = 1'b0;
    @(negedge PCLK);
    check("bp_next_accepted", {PSEL, PENABLE}, 2'b10);
    check("bp_next_addr", PADDR, 32'h20);
    drain();

    // Random commands against the reference model
    for (int i = 0; i < 60; i++) begin
      addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      r = int'($urandom_range(0, 9));
      if (r == 9) w = 1000;
      else if (r >= 7) w = int'($urandom_range(5, 8));
      else w = int'($urandom_range(0, 2));
      exec(addr, 1'($urandom), $urandom, 4'($urandom), w, ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 2)), 1'b0, 32'h0, 1'b0, 1'b0, 0);
    end

    // Reset while the slave is inserting wait states in ACCESS
    @(negedge PCLK);
    slv_waits = 5; slv_err = 1'b0;
    CMD_VALID = 1'b1; CMD_ADDR = 32'h3C; CMD_WRITE = 1'b1; CMD_WDATA = 32'hA5A5A5A5;
    CMD_STRB = 4'hF;
    @(posedge PCLK);
    #1 CMD_VALID = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check("rst_in_access", {PSEL, PENABLE}, 2'b11);
    PRESET = 1'b1;
    @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    check("rst_apb_dropped", {PSEL, PENABLE, RSP_VALID, CMD_READY}, 4'b0001);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (RSP_VALID || PSEL) seen = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
    end
    check("rst_no_response", seen, 1'b0);
    exec(32'h3C, 1'b0, 32'h0, 4'h0, 0, 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb4_cmd_master.md
Name: apb4_cmd_master

Overview:
- Single-outstanding APB4 master that converts a valid/ready command stream into APB4 transfers and returns each result on a valid/ready response stream.
- Sits directly upstream of APB4 slaves such as the APB4 memory.
- Back end of the AXI-to-APB path: the AXI side issues one command per beat; this block drives PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT and collects PRDATA/PREADY/PSLVERR.
- Adds a PREADY time-out so a hung slave cannot stall the bridge.

Parameters:
- AW, 32, address width.
- DW, 32, data width, multiple of 8.
- DS, DW/8, byte-strobe width.
- TIMEOUT, 256, maximum ACCESS-phase cycles with PREADY low before abort; 0 disables time-out.

Ports:
- PCLK  input  1  clock; all logic rising-edge.
- PRESET  input  1  synchronous active-high reset.
- CMD_VALID  input  1  command valid.
- CMD_READY  output  1  command accepted when high with CMD_VALID.
- CMD_ADDR  input  AW  transfer address.
- CMD_WRITE  input  1  1=write, 0=read.
- CMD_WDATA  input  DW  write data.
- CMD_STRB  input  DS  write byte strobes.
- CMD_PROT  input  3  protection attribute.
- RSP_VALID  output  1  response valid.
- RSP_READY  input  1  response consumed.
- RSP_RDATA  output  DW  read data.
- RSP_ERR  output  1  slave error or time-out.
- RSP_TIMEOUT  output  1  response produced by time-out abort.
- PSEL, PENABLE, PWRITE  output  1 each  APB4 control.
- PADDR  output  AW  APB4 address.
- PWDATA  output  DW  APB4 write data.
- PSTRB  output  DS  APB4 write strobes.
- PPROT  output  3  APB4 protection.
- PRDATA  input  DW  APB4 read data.
- PREADY  input  1  APB4 ready.
- PSLVERR  input  1  APB4 slave error.

Behaviour:
- Clock and reset: one clock domain (PCLK). Reset is synchronous and active-high (PRESET); it is sampled only on the PCLK rising edge.
- Reset values: all registered outputs are 0, state is IDLE, and the time-out counter is 0. CMD_READY is 1 in the first cycle after reset because it is decoded from IDLE.
- States: IDLE, SETUP, ACCESS, RESP.

IDLE
- CMD_READY = (state==IDLE).
- On CMD_VALID & CMD_READY, register CMD_ADDR, CMD_WRITE, CMD_WDATA and CMD_PROT onto PADDR, PWRITE, PWDATA and PPROT.
- Register PSTRB = CMD_WRITE ? CMD_STRB : 0; reads always drive PSTRB = 0.
- Set PSEL=1, PENABLE=0 and go to SETUP.
- With no CMD_VALID, stay in IDLE with PSEL=0.

SETUP
- Lasts exactly one cycle: PSEL=1, PENABLE=0.
- Next cycle PENABLE=1 and state goes to ACCESS.
- The time-out counter is cleared in this cycle.

ACCESS
- PSEL=1, PENABLE=1. PADDR, PWRITE, PWDATA, PSTRB and PPROT stay stable until the transfer completes.
- On an edge with PREADY=1:
  - capture RSP_RDATA = PWRITE ? 0 : PRDATA;
  - RSP_ERR = PSLVERR, RSP_TIMEOUT = 0;
  - clear PSEL and PENABLE, set RSP_VALID=1 and go to RESP.
- PSLVERR is sampled only when PREADY=1.
- With PREADY=0 the counter increments. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with PREADY still 0:
  - abort: clear PSEL and PENABLE;
  - RSP_RDATA = all ones, RSP_ERR=1, RSP_TIMEOUT=1, RSP_VALID=1, go to RESP.
- If PREADY=1 arrives on the same edge as the time-out, PREADY wins (normal completion).

RESP
- RSP_VALID=1 and the response fields are held stable until RSP_READY=1.
- On that edge RSP_VALID returns to 0 and state goes to IDLE.
- No command is accepted in RESP.

Timing
- Minimum command-accept-to-RSP_VALID latency is 3 edges: accept edge, SETUP, ACCESS with PREADY=1.
- Minimum accept-to-accept spacing is 4 cycles.
- Each wait state adds one cycle.

Other rules
- PADDR is passed through unmodified; no alignment or decode is done here.
- Width rule: the counter holds TIMEOUT-1 and is at least 1 bit wide.
- Reset mid-operation: the next edge forces the reset values. Any in-flight APB transfer is dropped mid-phase, no response is generated, and a pending RSP_VALID is discarded.

Test Plan:
- Write then read, slave with zero wait states:
  - write cmd ADDR=0x10, WDATA=0xDEADBEEF, STRB=0xF -> PSEL for 2 cycles, PENABLE high on the 2nd, PSTRB=0xF, RSP_ERR=0, RSP_RDATA=0;
  - read 0x10 -> PSTRB=0, RSP_RDATA=0xDEADBEEF, RSP_VALID 3 edges after accept.
- Partial strobe:
  - memory word at 0x20 holds 0xFFFFFFFF; write WDATA=0x11223344, STRB=0x5;
  - read back 0x20 -> 0xFF22FF44.
- Wait states and error:
  - slave holds PREADY low 3 cycles, then PREADY=1 with PSLVERR=1 -> PADDR/PWDATA stable throughout, RSP_ERR=1, RSP_TIMEOUT=0, latency 6 edges.
- Time-out:
  - TIMEOUT=8, PREADY tied 0 -> PSEL/PENABLE drop after 8 ACCESS cycles, RSP_RDATA=0xFFFFFFFF, RSP_ERR=1, RSP_TIMEOUT=1.
  - PREADY=1 on the 8th ACCESS cycle -> normal completion.
- Response back-pressure:
  - RSP_READY low 5 cycles with CMD_VALID held high -> CMD_READY=0 and response stable for all 5;
  - the next command is accepted the cycle after the RSP handshake.
- Reset in ACCESS:
  - assert PRESET for one cycle -> next edge PSEL=0, PENABLE=0, RSP_VALID=0, CMD_READY=1; no response is emitted for the aborted command.
